// File: rtl/twofish_pkg.sv
// Shared Twofish constants: GF(2^8) reduction polynomial, MDS matrix and the
// control states used by the iterative MDS stage.
package twofish_pkg;

  // Low byte of x^8 + x^6 + x^5 + x^3 + 1 (0x169); x^8 is implied.
  localparam logic [7:0] GF_POLY = 8'h69;

  // MDS_M[row][col]
  localparam logic [7:0] MDS_M [4][4] = '{
    '{8'h01, 8'hEF, 8'h5B, 8'h5B},
    '{8'h5B, 8'hEF, 8'hEF, 8'h01},
    '{8'hEF, 8'h5B, 8'h01, 8'hEF},
    '{8'hEF, 8'h01, 8'hEF, 8'h5B}
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mds_mix_unit_if.sv
// Input and output streams of the MDS stage. Both sides use valid/ready: a
// transfer happens on a rising edge where valid and ready are both high; a
// producer holds valid and data stable until that edge; ready never depends on
// the same side's valid.
interface mds_mix_unit_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/gf256_mul_const.sv
// Combinational GF(2^8) multiply p = a * k by shift-and-add; when k is a
// constant the unused partial products fold away.
module gf256_mul_const #(
  parameter logic [7:0] POLY = 8'h69
) (
  input  logic [7:0] a,
  input  logic [7:0] k,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ sh;
      // Multiply by x: shift, then reduce if the old bit 7 falls off.
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY : 8'h00);
    end
  end

  assign p = acc;

endmodule

// File: rtl/mds_mix_unit.sv
// Twofish MDS diffusion stage: z = MDS * y over GF(2^8), one output byte
// (matrix row) per clock, valid/ready on both sides.
module mds_mix_unit
  import twofish_pkg::*;
#(
  parameter logic [7:0] POLY = GF_POLY
) (
  input  logic           clk,
  input  logic           rst,
  mds_mix_unit_if.slave  bus,
  output logic           busy,
  output state_t         dbg_state
);

  state_t      state, state_n;
  logic [1:0]  row, row_n;
  logic [31:0] y_reg, y_n;
  logic [31:0] z_reg, z_n;
  logic [7:0]  prod [4];
  logic [7:0]  z_row;
  logic        s_ready_c;

  for (genvar c = 0; c < 4; c++) begin : g_col
    gf256_mul_const #(.POLY(POLY)) u_mul (
      .a (y_reg[8*c +: 8]),
      .k (MDS_M[row][c]),
      .p (prod[c])
    );
  end

  assign z_row = prod[0] ^ prod[1] ^ prod[2] ^ prod[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row   <= 2'd0;
      y_reg <= 32'h0;
      z_reg <= 32'h0;
    end else begin
      state <= state_n;
      row   <= row_n;
      y_reg <= y_n;
      z_reg <= z_n;
    end
  end

  always_comb begin
    state_n   = state;
    row_n     = row;
    y_n       = y_reg;
    z_n       = z_reg;
    s_ready_c = 1'b0;
    case (state)
      IDLE: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          y_n     = bus.s_data;
          row_n   = 2'd0;
          state_n = CALC;
        end
      end
      CALC: begin
        z_n[{row, 3'b000} +: 8] = z_row;
        row_n = row + 2'd1;
        if (row == 2'd3) state_n = DONE;
      end
      DONE: begin
        // Accepting in the release cycle keeps throughput at one word per 5 clocks.
        if (bus.m_ready) begin
          s_ready_c = 1'b1;
          if (bus.s_valid) begin
            y_n     = bus.s_data;
            row_n   = 2'd0;
            state_n = CALC;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.s_ready = s_ready_c;
  assign bus.m_valid = (state == DONE);
  assign bus.m_data  = z_reg;
  assign busy        = (state == CALC) || (state == DONE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_mds_mix_unit.sv
// Directed bench for mds_mix_unit: vector table of single words, then stall,
// back-to-back and mid-calculation reset sequences.
module tb_mds_mix_unit;
  import twofish_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   busy;
  state_t dbg_state;
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc   = 0;

  mds_mix_unit_if bus ();

  mds_mix_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] y;
    logic [31:0] z;
  } vec_t;

  vec_t vecs [7];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present y from a negedge and hold until the handshake edge, then scramble s_data.
  task automatic send(input logic [31:0] y, input string name);
    int waitc;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = y;
    waitc = 0;
    while (!bus.s_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.s_ready) check({name, " s_ready timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = $urandom;
  endtask

  // Called #1 after the handshake edge; counts edges until m_valid rises.
  task automatic wait_result(input logic [31:0] exp, input string name, output int lat);
    lat = 0;
    while (!bus.m_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, lat, 32'd4);
    check({name, " data"}, bus.m_data, exp);
  endtask

  // ---------------- test ----------------
  initial begin
    int lat;
    int t_a;
    logic [31:0] held;

    vecs[0] = '{32'h00000001, 32'hEFEF5B01};
    vecs[1] = '{32'h00000100, 32'h015BEFEF};
    vecs[2] = '{32'h00010000, 32'hEF01EF5B};
    vecs[3] = '{32'h01000000, 32'h5BEF015B};
    vecs[4] = '{32'h00000002, 32'hB7B7B602};
    vecs[5] = '{32'h00000101, 32'hEEB4B4EE};
    vecs[6] = '{32'h00000000, 32'h00000000};

    bus.s_valid = 1'b0;
    bus.s_data  = 32'h0;
    bus.m_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset s_ready", {31'd0, bus.s_ready}, 32'd1);
    check("reset m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("reset m_data",  bus.m_data, 32'd0);
    check("reset busy",    {31'd0, busy}, 32'd0);
    check("reset state",   {30'd0, dbg_state}, {30'd0, IDLE});

    // Table of single words, output never stalled.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].y, $sformatf("vec%0d", i));
      check($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd1);
      wait_result(vecs[i].z, $sformatf("vec%0d", i), lat);
      @(posedge clk);
      #1;
    end

    // Output stall: result held, pending word not consumed.
    bus.m_ready = 1'b0;
    send(32'h00000002, "stall");
    wait_result(32'hB7B7B602, "stall", lat);
    held = bus.m_data;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h00000100;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall hold %0d", i),
            {bus.m_valid, bus.s_ready, dbg_state, bus.m_data[27:0]},
            {1'b1, 1'b0, DONE, held[27:0]});
    end
    check("stall m_data full", bus.m_data, 32'hB7B7B602);
    @(negedge clk);
    bus.m_ready = 1'b1;
    #1;
    check("stall release s_ready", {31'd0, bus.s_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    check("stall pending accepted", {30'd0, dbg_state}, {30'd0, CALC});
    wait_result(32'h015BEFEF, "stall pending", lat);
    @(posedge clk);
    #1;

    // Back-to-back: second word accepted in the DONE cycle of the first.
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h00000001;
    @(posedge clk);
    #1;
    bus.s_data = 32'h01000000;
    wait_result(32'hEFEF5B01, "b2b first", lat);
    t_a = cyc;
    check("b2b s_ready in DONE", {31'd0, bus.s_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    check("b2b second accepted", {30'd0, dbg_state}, {30'd0, CALC});
    wait_result(32'h5BEF015B, "b2b second", lat);
    check("b2b spacing", cyc - t_a, 32'd5);
    @(posedge clk);
    #1;

    // Reset two cycles into CALC aborts the word.
    send(32'h00000101, "abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort state",   {30'd0, dbg_state}, {30'd0, IDLE});
    check("abort m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("abort m_data",  bus.m_data, 32'd0);
    check("abort busy",    {31'd0, busy}, 32'd0);
    send(32'h00000100, "after abort");
    wait_result(32'h015BEFEF, "after abort", lat);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
